// File: rtl/lcd_scanout_reader.sv
// Frame-buffer scanout: bursts pixel words from SDRAM into a word FIFO and unpacks 4 pixels/word, LSB first.
// Pixel output is 1 cycle after i_Pixel_Ready; an empty FIFO under demand sets a sticky o_Underflow.
module lcd_scanout_reader #(
    parameter int         BURST_LEN   = 8,
    parameter int         FRAME_WORDS = 96000,
    parameter int         FIFO_DEPTH  = 64,
    // Must match the command encodings used by the SDRAM controller.
    parameter logic [1:0] CMD_IDLE    = 2'b00,
    parameter logic [1:0] CMD_READ    = 2'b01
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    output logic        o_SDRAM_Request,
    input  logic        i_SDRAM_Yield,
    output logic [1:0]  o_Command,
    output logic [21:0] o_Data_Address,
    input  logic        i_Data_Read_Valid,
    input  logic [31:0] i_Data_Read,
    input  logic        i_Frame_Start,
    input  logic        i_Pixel_Ready,
    output logic [7:0]  o_Pixel,
    output logic        o_Pixel_Valid,
    output logic        o_Underflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [AW:0] MAX_FILL = (AW+1)'(FIFO_DEPTH - BURST_LEN);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_READ, S_DONE} state_t;

    state_t         state, state_nxt;
    logic [31:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [BW-1:0]  beat_cnt;
    logic [1:0]     byte_idx;
    logic           discard;
    logic [31:0]    rd_word;
    logic [21:0]    addr_inc;
    logic           room, last_beat, push, fifo_empty, take, pop;

    assign room       = (count <= MAX_FILL);
    assign last_beat  = (state == S_READ) && i_Data_Read_Valid && (beat_cnt == BW'(BURST_LEN - 1));
    assign push       = (state == S_READ) && i_Data_Read_Valid && !discard && !i_Frame_Start;
    assign fifo_empty = (count == '0);
    assign take       = i_Pixel_Ready && !fifo_empty && !i_Frame_Start;
    assign pop        = take && (byte_idx == 2'd3);
    assign rd_word    = mem[rd_ptr];
    assign addr_inc   = (o_Data_Address == 22'(FRAME_WORDS - 1)) ? 22'd0 : o_Data_Address + 22'd1;

    always_comb begin
        state_nxt       = state;
        o_SDRAM_Request = 1'b0;
        o_Command       = CMD_IDLE;
        case (state)
            S_IDLE: if (room) state_nxt = S_REQ;
            S_REQ: begin
                o_SDRAM_Request = 1'b1;
                if (i_SDRAM_Yield) state_nxt = S_READ;
            end
            S_READ: begin
                o_SDRAM_Request = 1'b1;
                o_Command       = CMD_READ;
                if (last_beat) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A frame restart during a burst lets the burst finish on the bus; the address rewinds once it ends.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state          <= S_IDLE;
            o_Data_Address <= '0;
            beat_cnt       <= '0;
            discard        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_READ) begin
                if (i_Data_Read_Valid)
                    beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
                if (i_Frame_Start)
                    discard <= 1'b1;
                if (last_beat && (discard || i_Frame_Start)) begin
                    o_Data_Address <= '0;
                    discard        <= 1'b0;
                end else if (i_Data_Read_Valid) begin
                    o_Data_Address <= addr_inc;
                end
            end else if (i_Frame_Start) begin
                o_Data_Address <= '0;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (push) mem[wr_ptr] <= i_Data_Read;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n || i_Frame_Start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            o_Pixel       <= '0;
            o_Pixel_Valid <= 1'b0;
            o_Underflow   <= 1'b0;
            byte_idx      <= '0;
        end else begin
            o_Pixel_Valid <= take;
            if (i_Frame_Start) begin
                byte_idx    <= '0;
                o_Underflow <= 1'b0;
            end else if (i_Pixel_Ready) begin
                if (fifo_empty) begin
                    o_Underflow <= 1'b1;
                end else begin
                    o_Pixel  <= rd_word[{byte_idx, 3'b000} +: 8];
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end
endmodule

// File: doc/lcd_scanout_reader.md
# lcd_scanout_reader

Frame-buffer scanout stage that consumes the pixel words written back to SDRAM by the Mandelbrot/Julia processor and streams them to the LCD timing generator. It requests the shared SDRAM port from the processor and waits for the yield. It then issues read bursts into an internal word FIFO and unpacks each 32-bit word into four 8-bit pixels on demand. Sits between the SDRAM controller command bus and the LCD pixel pipeline.

## Interface
- BURST_LEN, 8, words per SDRAM read burst; must equal the controller's READ_BURST_LENGTH.
- FRAME_WORDS, 96000, words per frame (800x480 at 8 bpp, 4 pixels/word).
- FIFO_DEPTH, 64, word FIFO depth; power of two, >= 2*BURST_LEN.
- i_Clk  in  1  system clock; all logic on rising edge.
- i_Rst_n  in  1  synchronous, active-low reset.
- o_SDRAM_Request  out  1  bus request to the processor (its i_SDRAM_Requested).
- i_SDRAM_Yield  in  1  processor grant (its o_SDRAM_Yield).
- o_Command  out  2  CMD_IDLE / CMD_READ, encodings from sdram.vh.
- o_Data_Address  out  22  SDRAM word address of the next read word.
- i_Data_Read_Valid  in  1  read word valid strobe.
- i_Data_Read  in  32  read word.
- i_Frame_Start  in  1  one-cycle pulse at LCD vsync.
- i_Pixel_Ready  in  1  LCD consumes one pixel this cycle.
- o_Pixel  out  8  pixel value, registered.
- o_Pixel_Valid  out  1  o_Pixel holds a real pixel this cycle.
- o_Underflow  out  1  sticky: a pixel was demanded with no data available.

## Operation
- Reset (i_Rst_n=0 at an edge) values: state IDLE, o_SDRAM_Request=0, o_Command=CMD_IDLE, o_Data_Address=0, o_Pixel=0, o_Pixel_Valid=0, o_Underflow=0, FIFO empty, byte index 0, discard flag 0. Reset mid-burst abandons the burst. The remaining words are ignored because o_Command is already IDLE.
- FSM states:
  - IDLE: if free = FIFO_DEPTH - count >= BURST_LEN, go to REQ.
  - REQ: o_SDRAM_Request=1. When i_SDRAM_Yield=1, go to READ and drive o_Command=CMD_READ from the next cycle.
  - READ: o_SDRAM_Request=1, o_Command=CMD_READ. Each i_Data_Read_Valid pushes i_Data_Read, unless discard is set, and increments o_Data_Address. After BURST_LEN valid strobes, go to DONE.
  - DONE: o_SDRAM_Request=0, o_Command=CMD_IDLE for exactly one cycle, so the processor can regain the bus. Then go to IDLE.
- Address wrap: an increment from FRAME_WORDS-1 yields 0. Bursts may straddle the wrap.
- Free-space check happens only in IDLE. A full burst therefore always fits, and FIFO overflow is impossible by construction.
- Pixel unpack order: byte[7:0] first, then [15:8], [23:16], [31:24]. The word is popped when byte 3 is consumed, and the byte index returns to 0.
- i_Pixel_Ready with FIFO non-empty: next cycle o_Pixel = selected byte and o_Pixel_Valid=1.
- i_Pixel_Ready with FIFO empty: next cycle o_Pixel_Valid=0, o_Pixel holds its previous value, and o_Underflow is set.
- i_Pixel_Ready=0: next cycle o_Pixel_Valid=0.
- i_Frame_Start:
  - Flushes the FIFO, zeroes the byte index, clears o_Underflow, and drives o_Pixel_Valid=0 next cycle. It wins over a simultaneous i_Pixel_Ready.
  - In IDLE/REQ/DONE: o_Data_Address becomes 0 immediately.
  - In READ: set discard. The current burst completes on the bus, and all remaining words, including one arriving in the same cycle as i_Frame_Start, are dropped. On leaving READ, o_Data_Address becomes 0 and discard clears.
- i_Frame_Start while discard is already set: no additional effect.

## Timing
- Request latency: IDLE to o_SDRAM_Request=1 takes one cycle.
- Grant latency: i_SDRAM_Yield=1 sampled in REQ gives o_Command=CMD_READ the following cycle. o_Data_Address is stable from that cycle.
- o_SDRAM_Request stays high from REQ through the last burst word. It drops in the cycle after the final i_Data_Read_Valid, together with o_Command returning to CMD_IDLE.
- Pixel latency: one cycle from i_Pixel_Ready to o_Pixel/o_Pixel_Valid.
- Data push to first pixel: a word pushed at edge N can be consumed by i_Pixel_Ready at N+1.
- Throughput: one pixel per cycle sustained if bursts keep pace.
- Minimum bus turnaround: one DONE cycle between successive bursts, plus the IDLE and REQ cycles.
- Simultaneous push and pop of the FIFO in the same cycle is legal; count is unchanged.

## Test plan
- Reset, then feed a burst of 8 words 0x03020100, 0x07060504, ... after the yield. Required: o_Data_Address steps 0..7, o_Command returns to IDLE with o_SDRAM_Request=0 after the 8th valid, and i_Pixel_Ready held high yields pixels 0x00, 0x01, ..., 0x1F in order.
- Hold i_SDRAM_Yield=0 for 20 cycles. Required: o_SDRAM_Request=1 and o_Command=CMD_IDLE throughout; CMD_READ appears exactly one cycle after the yield rises.
- Start with o_Data_Address=FRAME_WORDS-4 and run a burst of 8. Required: addresses 95996..95999, then 0..3.
- Assert i_Frame_Start during the 3rd valid word of a burst. Required: words 3..8 are discarded, FIFO is empty, the next burst starts at address 0, and o_Pixel_Valid=0 on the cycle after the pulse.
- i_Pixel_Ready high with an empty FIFO. Required: o_Pixel_Valid=0 and o_Underflow=1, which stays set until i_Frame_Start clears it.
- Stall i_Pixel_Ready until the FIFO holds 57 words. Required: no new request (free=7 < 8); a request issues one cycle after the count drops to 56.
